// File: rtl/nand_resp_checker.sv
// Checks an observed NAND response Y against operands A and B through a two-stage
// pipeline and keeps check/error counters plus a record of the first failing sample.
module nand_resp_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             vld,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             ff_vld,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic [WIDTH-1:0] ff_y,
    output logic [CNT_W-1:0] ff_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             drain_cnt;
    logic             restart;
    logic             s1_vld;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] nand_q;
    logic             mismatch;
    logic [CNT_W-1:0] chk_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             done_nxt;
    logic             pass_nxt;

    assign restart = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN lasts exactly two cycles so both pipeline stages have emptied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end else begin
            drain_cnt <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN) || (state == DRAIN);
        done_nxt = (state_nxt == DONE);
        pass_nxt = done_nxt && (err_nxt == '0) && (chk_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= done_nxt;
            pass <= pass_nxt;
        end
    end

    // Stage 1: capture the sample only while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            y_q    <= '0;
        end else begin
            s1_vld <= (state == RUN) && vld;
            if ((state == RUN) && vld) begin
                a_q <= A;
                b_q <= B;
                y_q <= Y;
            end
        end
    end

    // Stage 2: compare the registered sample and compute the saturating counts
    always_comb begin
        nand_q   = ~(a_q & b_q);
        mismatch = s1_vld && (y_q != nand_q);
        chk_nxt  = chk_cnt;
        err_nxt  = err_cnt;
        if (restart) begin
            chk_nxt = '0;
            err_nxt = '0;
        end else begin
            if (s1_vld && (chk_cnt != CNT_MAX)) chk_nxt = chk_cnt + 1'b1;
            if (mismatch && (err_cnt != CNT_MAX)) err_nxt = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_cnt <= '0;
            err_cnt <= '0;
        end else begin
            chk_cnt <= chk_nxt;
            err_cnt <= err_nxt;
        end
    end

    // Only the first mismatch of a run is recorded; its index is the pre-increment count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vld <= 1'b0;
            ff_a   <= '0;
            ff_b   <= '0;
            ff_y   <= '0;
            ff_idx <= '0;
        end else if (restart) begin
            ff_vld <= 1'b0;
            ff_a   <= '0;
            ff_b   <= '0;
            ff_y   <= '0;
            ff_idx <= '0;
        end else if (mismatch && !ff_vld) begin
            ff_vld <= 1'b1;
            ff_a   <= a_q;
            ff_b   <= b_q;
            ff_y   <= y_q;
            ff_idx <= chk_cnt;
        end
    end

endmodule

// File: tb/tb_nand_resp_checker.sv
// Self-checking bench for nand_resp_checker: samples are queued in a scoreboard as they
// are driven and the expected run results are derived from that queue when the run ends.
module tb_nand_resp_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
    } sample_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             ff_vld;
    logic [WIDTH-1:0] ff_a;
    logic [WIDTH-1:0] ff_b;
    logic [WIDTH-1:0] ff_y;
    logic [CNT_W-1:0] ff_idx;

    sample_t sb[$];
    int vectors;
    int miscompares;

    logic [CNT_W-1:0] exp_chk;
    logic [CNT_W-1:0] exp_err;
    logic             exp_ff_vld;
    logic [WIDTH-1:0] exp_ff_a;
    logic [WIDTH-1:0] exp_ff_b;
    logic [WIDTH-1:0] exp_ff_y;
    logic [CNT_W-1:0] exp_ff_idx;
    logic             exp_pass;

    nand_resp_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vld(vld),
        .A(a), .B(b), .Y(y),
        .busy(busy), .done(done), .pass(pass),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt),
        .ff_vld(ff_vld), .ff_a(ff_a), .ff_b(ff_b), .ff_y(ff_y), .ff_idx(ff_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb_, input logic [WIDTH-1:0] sy);
        sample_t s;
        vld = 1'b1; a = sa; b = sb_; y = sy;
        s.a = sa; s.b = sb_; s.y = sy;
        sb.push_back(s);
        tick();
        vld = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) break;
            tick();
        end
    endtask

    // Reference model: drains the scoreboard and derives the expected run results
    task automatic model_run();
        sample_t s;
        logic [WIDTH-1:0] nv;
        logic mis;
        exp_chk = '0; exp_err = '0; exp_ff_vld = 1'b0;
        exp_ff_a = '0; exp_ff_b = '0; exp_ff_y = '0; exp_ff_idx = '0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            nv = ~(s.a & s.b);
            mis = (s.y !== nv);
            if (mis && !exp_ff_vld) begin
                exp_ff_vld = 1'b1; exp_ff_a = s.a; exp_ff_b = s.b; exp_ff_y = s.y; exp_ff_idx = exp_chk;
            end
            if (exp_chk != '1) exp_chk = exp_chk + 1'b1;
            if (mis && exp_err != '1) exp_err = exp_err + 1'b1;
        end
        exp_pass = (exp_err == '0) && (exp_chk != '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; vld = 1'b0; a = '0; b = '0; y = '0;
        tick(); tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b exp 0", done); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pass got %b exp 0", pass); end
        vectors++; if (chk_cnt !== '0) begin miscompares++; $display("[TB] FAIL reset_chk got %0d exp 0", chk_cnt); end
        vectors++; if (err_cnt !== '0) begin miscompares++; $display("[TB] FAIL reset_err got %0d exp 0", err_cnt); end
        vectors++; if ({ff_vld, ff_a, ff_b, ff_y, ff_idx} !== '0) begin miscompares++; $display("[TB] FAIL reset_ff got %b/%b/%b/%b/%0d exp all 0", ff_vld, ff_a, ff_b, ff_y, ff_idx); end
        rst_n = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_clean_run();
        start_run();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL clean_busy got %b exp 1", busy); end
        send(4'b0000, 4'b1111, 4'b1111);
        send(4'b0010, 4'b0110, 4'b1101);
        send(4'b0111, 4'b0100, 4'b1011);
        send(4'b0000, 4'b1110, 4'b1111);
        stop_run();
        wait_done();
        model_run();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL clean_done got %b exp 1", done); end
        vectors++; if (pass !== exp_pass) begin miscompares++; $display("[TB] FAIL clean_pass got %b exp %b", pass, exp_pass); end
        vectors++; if (chk_cnt !== exp_chk) begin miscompares++; $display("[TB] FAIL clean_chk got %0d exp %0d", chk_cnt, exp_chk); end
        vectors++; if (err_cnt !== exp_err) begin miscompares++; $display("[TB] FAIL clean_err got %0d exp %0d", err_cnt, exp_err); end
        vectors++; if (ff_vld !== exp_ff_vld) begin miscompares++; $display("[TB] FAIL clean_ffvld got %b exp %b", ff_vld, exp_ff_vld); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_busy_done got %b exp 0", busy); end
    endtask

    task automatic test_fault_injection();
        start_run();
        vectors++; if ({chk_cnt, err_cnt, pass, done} !== '0) begin miscompares++; $display("[TB] FAIL fault_restart_clear got %0d/%0d/%b/%b exp 0/0/0/0", chk_cnt, err_cnt, pass, done); end
        send(4'b0000, 4'b1111, 4'b1111);
        send(4'b0010, 4'b0110, 4'b1111);
        send(4'b0111, 4'b0100, 4'b0000);
        send(4'b0000, 4'b1110, 4'b1111);
        stop_run();
        wait_done();
        model_run();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL fault_done got %b exp 1", done); end
        vectors++; if (pass !== exp_pass) begin miscompares++; $display("[TB] FAIL fault_pass got %b exp %b", pass, exp_pass); end
        vectors++; if (chk_cnt !== exp_chk) begin miscompares++; $display("[TB] FAIL fault_chk got %0d exp %0d", chk_cnt, exp_chk); end
        vectors++; if (err_cnt !== exp_err) begin miscompares++; $display("[TB] FAIL fault_err got %0d exp %0d", err_cnt, exp_err); end
        vectors++; if (ff_vld !== exp_ff_vld) begin miscompares++; $display("[TB] FAIL fault_ffvld got %b exp %b", ff_vld, exp_ff_vld); end
        vectors++; if (ff_idx !== exp_ff_idx) begin miscompares++; $display("[TB] FAIL fault_ffidx got %0d exp %0d", ff_idx, exp_ff_idx); end
        vectors++; if ({ff_a, ff_b, ff_y} !== {exp_ff_a, exp_ff_b, exp_ff_y}) begin miscompares++; $display("[TB] FAIL fault_ffdata got %b/%b/%b exp %b/%b/%b", ff_a, ff_b, ff_y, exp_ff_a, exp_ff_b, exp_ff_y); end
    endtask

    task automatic test_latency_drain();
        start_run();
        send(4'b0101, 4'b0011, 4'b1110);
        vectors++; if (chk_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL lat_chk_1clk got %0d exp 0", chk_cnt); end
        stop_run();
        vectors++; if (chk_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL lat_chk_2clk got %0d exp 1", chk_cnt); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_done_1clk got %b exp 0", done); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_done_2clk got %b exp 0", done); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_busy_drain got %b exp 1", busy); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_done_3clk got %b exp 1", done); end
        model_run();
        vectors++; if (pass !== exp_pass) begin miscompares++; $display("[TB] FAIL lat_pass got %b exp %b", pass, exp_pass); end
    endtask

    task automatic test_saturation();
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        start_run();
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom_range(0, 15));
            rb = WIDTH'($urandom_range(0, 15));
            send(ra, rb, ra & rb);
        end
        stop_run();
        wait_done();
        model_run();
        vectors++; if (chk_cnt !== exp_chk) begin miscompares++; $display("[TB] FAIL sat_chk got %0d exp %0d", chk_cnt, exp_chk); end
        vectors++; if (err_cnt !== exp_err) begin miscompares++; $display("[TB] FAIL sat_err got %0d exp %0d", err_cnt, exp_err); end
        vectors++; if (ff_idx !== exp_ff_idx) begin miscompares++; $display("[TB] FAIL sat_ffidx got %0d exp %0d", ff_idx, exp_ff_idx); end
        vectors++; if (pass !== exp_pass) begin miscompares++; $display("[TB] FAIL sat_pass got %b exp %b", pass, exp_pass); end
        tick(); tick(); tick();
        vectors++; if ({chk_cnt, err_cnt} !== {exp_chk, exp_err}) begin miscompares++; $display("[TB] FAIL sat_hold got %0d/%0d exp %0d/%0d", chk_cnt, err_cnt, exp_chk, exp_err); end
    endtask

    task automatic test_reset_midrun();
        start_run();
        send(4'b1111, 4'b1111, 4'b1111);
        send(4'b1010, 4'b1100, 4'b0000);
        vectors++; if ({chk_cnt, ff_vld} !== {4'd1, 1'b1}) begin miscompares++; $display("[TB] FAIL rst_pre got %0d/%b exp 1/1", chk_cnt, ff_vld); end
        rst_n = 1'b0;
        #2;
        vectors++; if ({busy, done, pass} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_async_flags got %b%b%b exp 000", busy, done, pass); end
        vectors++; if ({chk_cnt, err_cnt} !== '0) begin miscompares++; $display("[TB] FAIL rst_async_cnt got %0d/%0d exp 0/0", chk_cnt, err_cnt); end
        vectors++; if ({ff_vld, ff_a, ff_b, ff_y, ff_idx} !== '0) begin miscompares++; $display("[TB] FAIL rst_async_ff got %b/%b/%b/%b/%0d exp all 0", ff_vld, ff_a, ff_b, ff_y, ff_idx); end
        sb.delete();
        tick();
        rst_n = 1'b1;
        stop_run();
        tick(); tick();
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_stop_idle got %b%b exp 00", busy, done); end
        vectors++; if (chk_cnt !== '0) begin miscompares++; $display("[TB] FAIL rst_no_inflight got %0d exp 0", chk_cnt); end
    endtask

    task automatic test_ignored_inputs();
        vld = 1'b1; a = 4'b1111; b = 4'b1111; y = 4'b1111;
        tick(); tick(); tick();
        vld = 1'b0;
        tick(); tick();
        vectors++; if ({chk_cnt, err_cnt, busy} !== '0) begin miscompares++; $display("[TB] FAIL ign_idle got %0d/%0d/%b exp 0/0/0", chk_cnt, err_cnt, busy); end
        start = 1'b1;
        tick();
        send(4'b0011, 4'b0101, 4'b1110);
        send(4'b1100, 4'b1010, 4'b1000);
        tick(); tick();
        vectors++; if (chk_cnt !== CNT_W'(sb.size())) begin miscompares++; $display("[TB] FAIL ign_start_run got %0d exp %0d", chk_cnt, sb.size()); end
        stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_start_stop got busy %b done %b exp 1/0", busy, done); end
        vld = 1'b1; a = 4'b0000; b = 4'b0000; y = 4'b0000;
        tick();
        vld = 1'b0;
        wait_done();
        model_run();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_done got %b exp 1", done); end
        vectors++; if ({chk_cnt, err_cnt} !== {exp_chk, exp_err}) begin miscompares++; $display("[TB] FAIL ign_drain_vld got %0d/%0d exp %0d/%0d", chk_cnt, err_cnt, exp_chk, exp_err); end
        vld = 1'b1;
        tick();
        vld = 1'b0;
        tick(); tick();
        vectors++; if (chk_cnt !== exp_chk) begin miscompares++; $display("[TB] FAIL ign_done_vld got %0d exp %0d", chk_cnt, exp_chk); end
        start_run();
        vectors++; if ({chk_cnt, err_cnt, ff_vld} !== '0) begin miscompares++; $display("[TB] FAIL ign_restart_clear got %0d/%0d/%b exp 0/0/0", chk_cnt, err_cnt, ff_vld); end
        vectors++; if ({busy, done, pass} !== 3'b100) begin miscompares++; $display("[TB] FAIL ign_restart_flags got %b%b%b exp 100", busy, done, pass); end
        stop_run();
        wait_done();
        vectors++; if ({done, pass} !== 2'b10) begin miscompares++; $display("[TB] FAIL ign_empty_run got done %b pass %b exp 1/0", done, pass); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_clean_run();
        test_fault_injection();
        test_latency_drain();
        test_saturation();
        test_reset_midrun();
        test_ignored_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nand_resp_checker.md
NAND_RESP_CHECKER -- requirements
Module: nand_resp_checker

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the A, B and Y operand buses.
REQ-002 Parameter CNT_W, default 8: width of the check and error counters.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin or restart a check run (pulse).
REQ-007 stop  input  1  end the run; flush the pipeline (pulse).
REQ-008 vld  input  1  the A/B/Y sample is valid this cycle.
REQ-009 A  input  WIDTH  stimulus operand A applied to the device under check.
REQ-010 B  input  WIDTH  stimulus operand B.
REQ-011 Y  input  WIDTH  observed NAND response.
REQ-012 busy  output  1  high in RUN or DRAIN.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  high in DONE when err_cnt==0 and chk_cnt!=0.
REQ-015 chk_cnt  output  CNT_W  number of samples checked.
REQ-016 err_cnt  output  CNT_W  number of mismatching samples.
REQ-017 ff_vld  output  1  a first-failure record has been captured.
REQ-018 ff_a, ff_b, ff_y  output  WIDTH each  A, B and Y of the first failing sample.
REQ-019 ff_idx  output  CNT_W  chk_cnt value before the first failing sample was counted, i.e. its 0-based index.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-021 In IDLE or DONE, start SHALL cause a transition to RUN on the next edge and clear chk_cnt, err_cnt, ff_* and the pipeline.
REQ-022 In RUN, stop SHALL cause a transition to DRAIN; in DRAIN the FSM SHALL go to DONE after exactly 2 cycles so that both pipeline stages empty.
REQ-023 start SHALL be ignored in RUN and DRAIN; in RUN, a start asserted together with stop SHALL be ignored and stop SHALL take effect.
REQ-024 Stage 1: when state==RUN and vld==1, A, B and Y SHALL be registered together with a valid bit; in every other case the stage-1 valid bit SHALL be registered as 0.
REQ-025 Stage 2: a registered stage-1 sample SHALL be compared as mismatch = (y_q != ~(a_q & b_q)), bitwise over all WIDTH bits.
REQ-026 The counters SHALL update on the edge after the compare, giving a latency of 2 clocks from a sampled vld to a visible chk_cnt or err_cnt change.
REQ-027 chk_cnt SHALL increment by 1 per valid compared sample; err_cnt SHALL increment by 1 per mismatch.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 On the first mismatch of a run, ff_vld SHALL set to 1 and ff_a, ff_b, ff_y and ff_idx SHALL capture that sample; later mismatches SHALL NOT overwrite the record.
REQ-030 A vld asserted in IDLE, DRAIN or DONE SHALL be ignored: no sampling and no counting.
REQ-031 Samples already in the pipeline when stop is asserted SHALL still be checked and counted.
REQ-032 Outputs done and pass SHALL be registered; pass SHALL be 0 outside DONE.
REQ-033 A run with zero checked samples SHALL end in DONE with pass=0.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE and busy=0, done=0, pass=0, chk_cnt=0, err_cnt=0, ff_vld=0, ff_a=0, ff_b=0, ff_y=0 and ff_idx=0, and SHALL clear the pipeline valid bits.
REQ-035 Reset asserted mid-run SHALL discard all in-flight samples; after release the block SHALL stay in IDLE until start.

Verification
REQ-036 Clean run: start; vld with (A,B,Y) = (0000,1111,1111), (0010,0110,1101), (0111,0100,1011), (0000,1110,1111); stop -> done=1, pass=1, chk_cnt=4, err_cnt=0, ff_vld=0.
REQ-037 Fault injection: the same 4 samples with sample 2 Y=1111 and sample 3 Y=0000 -> err_cnt=2, pass=0, ff_idx=1, ff_a=0010, ff_b=0110, ff_y=1111.
REQ-038 Latency/drain: a single vld sample with stop in the next cycle -> chk_cnt becomes 1 two clocks after vld; done rises 3 clocks after stop.
REQ-039 Saturation with CNT_W=4: 20 mismatching samples -> chk_cnt=15 and err_cnt=15, held with no wrap.
REQ-040 Reset mid-run: rst_n low after 2 samples -> all outputs return to 0 asynchronously; stop alone then leaves the FSM in IDLE.
REQ-041 Ignored inputs: vld in IDLE and start held high during RUN -> no counting in IDLE; the start during RUN does not clear the counters; start in DONE restarts the run with the counters cleared.
